// File: rtl/priority_encoder.sv
// Registered 10-to-4 keypad priority encoder: the highest-numbered pressed key wins.
// data_valid separates "key 0 pressed" from "no key pressed", since both give bcd = 0.
module priority_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] keypad,
    input  logic       enablen,
    output logic [3:0] bcd,
    output logic       data_valid
);

    logic [3:0] bcd_d;
    logic [3:0] bcd_q;
    logic       vld_d;
    logic       vld_q;

    // Scan upward so that later (higher) set bits override earlier ones.
    function automatic logic [3:0] highest_key(input logic [9:0] keys);
        logic [3:0] idx;
        idx = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (keys[k]) begin
                idx = 4'(k);
            end
        end
        return idx;
    endfunction

    always_comb begin
        bcd_d = 4'd0;
        vld_d = 1'b0;
        if (!enablen && (keypad != 10'd0)) begin
            bcd_d = highest_key(keypad);
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q <= 4'd0;
            vld_q <= 1'b0;
        end else begin
            bcd_q <= bcd_d;
            vld_q <= vld_d;
        end
    end

    assign bcd        = bcd_q;
    assign data_valid = vld_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder: directed scenarios plus randomized traffic
// compared against an arithmetic reference model (floor(log2) of the key vector).
module tb_priority_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] keypad;
    logic       enablen;
    logic [3:0] bcd;
    logic       data_valid;

    int tests = 0;
    int fails = 0;

    priority_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .keypad     (keypad),
        .enablen    (enablen),
        .bcd        (bcd),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    // Reference: the highest set bit is floor(log2(keypad)), found by halving.
    task automatic ref_model(input logic [9:0] kp, input logic en_n, input logic r,
                             output logic [3:0] exp_bcd, output logic exp_vld);
        int v;
        int n;
        exp_bcd = 4'd0;
        exp_vld = 1'b0;
        if (!r && !en_n && kp != 10'd0) begin
            v = int'(kp);
            n = 0;
            while (v > 1) begin
                v = v / 2;
                n = n + 1;
            end
            exp_bcd = 4'(n);
            exp_vld = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; keypad = 10'h3FF; enablen = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests++;
            if (bcd !== 4'd0 || data_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold cycle %0d: got bcd=%0d vld=%b, expected bcd=0 vld=0", c, bcd, data_valid);
            end
        end
        rst = 1'b0;
        tick();
        tests++;
        if (bcd !== 4'd9 || data_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: got bcd=%0d vld=%b, expected bcd=9 vld=1", bcd, data_valid);
        end
    endtask

    task automatic test_onehot();
        enablen = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            keypad = 10'(1 << i);
            for (int c = 0; c < 2; c++) begin
                tick();
                tests++;
                if (bcd !== 4'(i) || data_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL onehot key %0d: got bcd=%0d vld=%b, expected bcd=%0d vld=1", i, bcd, data_valid, i);
                end
            end
        end
        keypad = 10'h001;
        tick();
        tests++;
        if (bcd !== 4'd0 || data_valid !== 1'b1) begin
            fails++;
            $display("FAIL onehot key 0: got bcd=%0d vld=%b, expected bcd=0 vld=1", bcd, data_valid);
        end
    endtask

    task automatic test_no_key();
        enablen = 1'b0; keypad = 10'h000;
        tick();
        tests++;
        if (bcd !== 4'd0 || data_valid !== 1'b0) begin
            fails++;
            $display("FAIL no_key: got bcd=%0d vld=%b, expected bcd=0 vld=0", bcd, data_valid);
        end
        keypad = 10'h010;
        tick();
        tests++;
        if (bcd !== 4'd4 || data_valid !== 1'b1) begin
            fails++;
            $display("FAIL no_key_then_4: got bcd=%0d vld=%b, expected bcd=4 vld=1", bcd, data_valid);
        end
    endtask

    task automatic test_priority();
        logic [9:0] pats [3];
        logic [3:0] exps [3];
        pats[0] = 10'h0A4; exps[0] = 4'd7;
        pats[1] = 10'h3FF; exps[1] = 4'd9;
        pats[2] = 10'h003; exps[2] = 4'd1;
        enablen = 1'b0;
        for (int p = 0; p < 3; p++) begin
            keypad = pats[p];
            tick();
            tests++;
            if (bcd !== exps[p] || data_valid !== 1'b1) begin
                fails++;
                $display("FAIL priority %h: got bcd=%0d vld=%b, expected bcd=%0d vld=1", pats[p], bcd, data_valid, exps[p]);
            end
        end
    endtask

    task automatic test_disable();
        keypad = 10'h020; enablen = 1'b1;
        tick();
        tests++;
        if (bcd !== 4'd0 || data_valid !== 1'b0) begin
            fails++;
            $display("FAIL disabled: got bcd=%0d vld=%b, expected bcd=0 vld=0", bcd, data_valid);
        end
        enablen = 1'b0;
        tick();
        tests++;
        if (bcd !== 4'd5 || data_valid !== 1'b1) begin
            fails++;
            $display("FAIL reenable: got bcd=%0d vld=%b, expected bcd=5 vld=1", bcd, data_valid);
        end
        enablen = 1'b1;
        tick();
        tests++;
        if (bcd !== 4'd0 || data_valid !== 1'b0) begin
            fails++;
            $display("FAIL redisable: got bcd=%0d vld=%b, expected bcd=0 vld=0", bcd, data_valid);
        end
    endtask

    task automatic test_latency();
        enablen = 1'b0; keypad = 10'h004;
        tick();
        tests++;
        if (bcd !== 4'd2 || data_valid !== 1'b1) begin
            fails++;
            $display("FAIL latency_setup: got bcd=%0d vld=%b, expected bcd=2 vld=1", bcd, data_valid);
        end
        keypad = 10'h100;
        #2;
        tests++;
        if (bcd !== 4'd2) begin
            fails++;
            $display("FAIL latency_hold: got bcd=%0d, expected bcd=2", bcd);
        end
        tick();
        tests++;
        if (bcd !== 4'd8 || data_valid !== 1'b1) begin
            fails++;
            $display("FAIL latency_update: got bcd=%0d vld=%b, expected bcd=8 vld=1", bcd, data_valid);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_bcd;
        logic       exp_vld;
        for (int c = 0; c < 400; c++) begin
            keypad  = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) keypad = 10'h000;
            enablen = ($urandom_range(0, 5) == 0);
            rst     = ($urandom_range(0, 15) == 0);
            ref_model(keypad, enablen, rst, exp_bcd, exp_vld);
            tick();
            tests++;
            if (bcd !== exp_bcd || data_valid !== exp_vld || bcd > 4'd9) begin
                fails++;
                $display("FAIL random cycle %0d kp=%h en_n=%b rst=%b: got bcd=%0d vld=%b, expected bcd=%0d vld=%b",
                         c, keypad, enablen, rst, bcd, data_valid, exp_bcd, exp_vld);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_bcd;
        logic       exp_vld;
        enablen = 1'b0; rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            keypad = 10'(1 << (c % 10)) | 10'($urandom_range(0, 1023) & ((1 << (c % 10)) - 1));
            ref_model(keypad, enablen, rst, exp_bcd, exp_vld);
            tick();
            tests++;
            if (bcd !== exp_bcd || data_valid !== exp_vld) begin
                fails++;
                $display("FAIL back_to_back cycle %0d kp=%h: got bcd=%0d vld=%b, expected bcd=%0d vld=%b",
                         c, keypad, bcd, data_valid, exp_bcd, exp_vld);
            end
        end
    endtask

    initial begin
        rst = 1'b1; keypad = 10'h000; enablen = 1'b1;
        tick();
        test_reset();
        test_onehot();
        test_no_key();
        test_priority();
        test_disable();
        test_latency();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
